// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   uart_state_e    : frame state encoding (IDLE=0, START=1, DATA=2,
//                     PARITY=3, STOP=4); PARITY is only reached when the
//                     transmitter is built with UART_TX_PARITY_EN.
//   BIT_CLK_DEFAULT : default number of clk cycles per serial bit.
//   even_parity()   : XOR of the 8 data bits (parity bit for even parity).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int BIT_CLK_DEFAULT = 87;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Bit-period counter. Counts 0..BIT_CLK-1 while enabled and wraps to 0 after
// the last count, so each bit period is exactly BIT_CLK cycles.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high; forces count to 0
//   clear    : synchronous clear, overrides enable
//   enable   : count this cycle
//   bit_done : high while enabled and count == BIT_CLK-1 (last cycle of a bit)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int BIT_CLK = 87
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_done
);

   localparam logic [7:0] LAST = 8'(BIT_CLK - 1);

   logic [7:0] count;

   assign bit_done = enable && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable) begin
         // Wrapping here is what clears the count on every state change,
         // because the FSM only changes state on bit_done.
         if (bit_done) begin
            count <= 8'd0;
         end else begin
            count <= count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-bit UART transmitter with cts flow control: start bit, 8 data bits LSB
// first, optional even parity bit, one stop bit. Each bit lasts BIT_CLK clks.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-bit frame). Without it the frame is
// 10 bits and no parity logic exists.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset; line goes high at once
//   txdata    : byte to send, captured only on the handshake
//   tx_valid  : txdata is valid
//   tx_ready  : transmitter accepts a byte this cycle
//   cts       : clear-to-send from the far end; only looked at in IDLE
//   txd       : serial line (registered), idle high
//   busy      : high while a frame is in flight (state != IDLE)
//   state_dbg : current FSM state (uart_state_e encoding)
//
// Handshake: a byte is transferred on a rising edge where tx_valid and
// tx_ready are both high. tx_ready = (state==IDLE) && cts and is forced low
// while reset is asserted; tx_valid may come and go freely and txdata is
// ignored on every other cycle. The frame's start bit appears on txd in the
// cycle right after the handshake cycle.
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_CLK = BIT_CLK_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] txdata,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       cts,
   output logic       txd,
   output logic       busy,
   output logic [2:0] state_dbg
);

   uart_state_e state;
   logic [7:0]  data;
   logic [2:0]  index;
   logic        bit_done;
   logic        timer_clear;
   logic        timer_enable;

   // cts is only meaningful in IDLE; once a frame starts it runs to the end.
   assign tx_ready  = (state == ST_IDLE) && cts && !reset;
   assign state_dbg = state;

   // The timer idles at 0 in IDLE so START gets a full bit period.
   assign timer_clear  = (state == ST_IDLE);
   assign timer_enable = (state != ST_IDLE);

   uart_bit_timer #(
      .BIT_CLK (BIT_CLK)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .bit_done (bit_done)
   );

   // txd and busy are set together with the state they belong to, so they
   // are registered and change on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         txd   <= 1'b1;
         busy  <= 1'b0;
         data  <= 8'd0;
         index <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx_valid && tx_ready) begin
                  data  <= txdata;
                  index <= 3'd0;
                  state <= ST_START;
                  txd   <= 1'b0;
                  busy  <= 1'b1;
               end
            end

            ST_START: begin
               if (bit_done) begin
                  state <= ST_DATA;
                  txd   <= data[0];
               end
            end

            ST_DATA: begin
               if (bit_done) begin
                  if (index == 3'd7) begin
                     index <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     state <= ST_PARITY;
                     txd   <= even_parity(data);
`else
                     state <= ST_STOP;
                     txd   <= 1'b1;
`endif
                  end else begin
                     index <= index + 3'd1;
                     txd   <= data[index + 3'd1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_done) begin
                  state <= ST_STOP;
                  txd   <= 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_done) begin
                  state <= ST_IDLE;
                  txd   <= 1'b1;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. A BIT_CLK=4 instance is checked every cycle against a
// frame-level model (queue of expected line levels); a BIT_CLK=87 instance is
// checked with a software loopback receiver and start-to-start spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int BC = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_N = 11;
`else
   localparam int FRAME_N = 10;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT (BIT_CLK=4) ----------------
   logic [7:0] txdata   = 8'd0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       cts      = 1'b1;
   logic       txd;
   logic       busy;
   logic [2:0] state_dbg;

   uart_tx #(.BIT_CLK(BC)) dut (
      .clk       (clk),
      .reset     (reset),
      .txdata    (txdata),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .cts       (cts),
      .txd       (txd),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- DUT (BIT_CLK=87) ----------------
   logic [7:0] txdata87   = 8'd0;
   logic       tx_valid87 = 1'b0;
   logic       tx_ready87;
   logic       txd87;
   logic       busy87;
   logic [2:0] state87;

   uart_tx #(.BIT_CLK(87)) dut87 (
      .clk       (clk),
      .reset     (reset),
      .txdata    (txdata87),
      .tx_valid  (tx_valid87),
      .tx_ready  (tx_ready87),
      .cts       (1'b1),
      .txd       (txd87),
      .busy      (busy87),
      .state_dbg (state87)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   // Expected txd level for each remaining cycle of the frame in flight.
   logic [0:0] exp_q[$];
   int         frames_seen = 0;

   task automatic push_frame(input logic [7:0] b);
      logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b0, 1'b1, b, 1'b0};
`endif
      for (int k = 0; k < FRAME_N; k++)
         for (int c = 0; c < BC; c++)
            exp_q.push_back(bits[k]);
      frames_seen++;
   endtask

   // Model: empty queue means idle. Inputs are driven just after posedge, so
   // at negedge they are what the next posedge will see.
   logic e_txd, e_busy, e_ready;
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         e_txd = 1'b1; e_busy = 1'b0; e_ready = 1'b0;
      end else if (exp_q.size() > 0) begin
         e_txd = exp_q[0]; e_busy = 1'b1; e_ready = 1'b0;
      end else begin
         e_txd = 1'b1; e_busy = 1'b0; e_ready = cts;
      end
      check("cmp_txd",   txd,      e_txd);
      check("cmp_busy",  busy,     e_busy);
      check("cmp_ready", tx_ready, e_ready);
      check("cmp_idle",  (state_dbg == 3'd0), !e_busy);
      if (!reset) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         else if (tx_valid && cts) push_frame(txdata);
      end
   end

   // ---------------- loopback receiver for the 87-cycle instance ----------------
   logic [7:0] rx_q[$];
   int         start_q[$];

   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b1;
         end else begin
            if (prev && !txd87) begin
               start_q.push_back(cyc);
               repeat (43) @(negedge clk);
               check("rx_start", txd87, 1'b0);
               for (int i = 0; i < 8; i++) begin
                  repeat (87) @(negedge clk);
                  b[i] = txd87;
               end
`ifdef UART_TX_PARITY_EN
               repeat (87) @(negedge clk);
               check("rx_parity", txd87, ^b);
`endif
               repeat (87) @(negedge clk);
               check("rx_stop", txd87, 1'b1);
               rx_q.push_back(b);
            end
            prev = txd87;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] b);
      int n;
      @(posedge clk); #1;
      txdata   = b;
      tx_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_ready && n < 200);
      if (!tx_ready) check("send_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      txdata   = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 500);
      if (busy) check("idle_timeout", busy, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   logic [10:0] t1_exp;
   int          busy_cnt;
   int          ready_hi;
   int          n;

   initial begin
`ifdef UART_TX_PARITY_EN
      t1_exp = 11'b10101001010;
`else
      t1_exp = 11'b01101001010;
`endif
      // Reset state with cts high: ready must still be low.
      repeat (3) @(negedge clk);
      check("rst_txd",   txd,      1'b1);
      check("rst_busy",  busy,     1'b0);
      check("rst_ready", tx_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", tx_ready, 1'b1);

      // Test 1: 0xA5 frame, level per bit and busy window.
      send(8'hA5);
      busy_cnt = 0;
      ready_hi = 0;
      for (int i = 0; i < FRAME_N * BC; i++) begin
         @(negedge clk);
         check("t1_level", txd, t1_exp[i / BC]);
         if (busy) busy_cnt++;
         if (tx_ready) ready_hi++;
      end
      @(negedge clk);
      check("t1_busy_cycles", busy_cnt, FRAME_N * BC);
      check("t1_ready_low", ready_hi, 0);
      check("t1_busy_end", busy, 1'b0);

      // Test 2: valid held, cts low for 20 cycles.
      @(posedge clk); #1;
      cts      = 1'b0;
      txdata   = 8'h5A;
      tx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t2_hold_txd",  txd,  1'b1);
         check("t2_hold_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      cts = 1'b1;
      @(negedge clk);
      check("t2_ready", tx_ready, 1'b1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      @(negedge clk);
      check("t2_start", txd, 1'b0);
      wait_idle();

      // Test 3: cts drops during data bit 3; frame completes, next byte waits.
      send(8'h3C);
      repeat (16) @(posedge clk);
      #1;
      cts      = 1'b0;
      txdata   = 8'h81;
      tx_valid = 1'b1;
      busy_cnt = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy) busy_cnt++;
      end while (busy && n < 100);
      check("t3_remaining", busy_cnt, FRAME_N * BC - 16);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_wait_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      cts = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      wait_idle();

      // Test 4: reset mid-data of 0xFF, then 0x00.
      send(8'hFF);
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("t4_txd",   txd,      1'b1);
      check("t4_busy",  busy,     1'b0);
      check("t4_ready", tx_ready, 1'b0);
      @(posedge clk); #3;
      reset = 1'b0;
      send(8'h00);
      wait_idle();

`ifdef UART_TX_PARITY_EN
      // Test 5: parity bit values and 44-cycle frame.
      send(8'h07);
      busy_cnt = 0;
      for (int i = 0; i < FRAME_N * BC; i++) begin
         @(negedge clk);
         if (i == 37) check("t5_par_07", txd, 1'b1);
         if (busy) busy_cnt++;
      end
      check("t5_len", busy_cnt, 44);
      wait_idle();
      send(8'h03);
      for (int i = 0; i < FRAME_N * BC; i++) begin
         @(negedge clk);
         if (i == 37) check("t5_par_03", txd, 1'b0);
      end
      wait_idle();
`endif

      // Random traffic: cts, tx_valid and txdata change every cycle.
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         cts      = ($urandom_range(0, 7) != 0);
         tx_valid = 1'($urandom_range(0, 1));
         txdata   = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
      cts      = 1'b1;
      wait_idle();
      @(negedge clk);
      check("rand_frames_accepted", (frames_seen > 20), 1'b1);

      // Test 6: BIT_CLK=87 back-to-back 0x55, 0xAA with loopback receive.
      @(posedge clk); #1;
      txdata87   = 8'h55;
      tx_valid87 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!tx_ready87 && n < 50);
      check("t6_hs1", tx_ready87, 1'b1);
      @(posedge clk); #1;
      txdata87 = 8'hAA;
      n = 0;
      do begin @(negedge clk); n++; end while (!tx_ready87 && n < 2000);
      check("t6_hs2", tx_ready87, 1'b1);
      @(posedge clk); #1;
      tx_valid87 = 1'b0;
      n = 0;
      while (rx_q.size() < 2 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t6_rx_count", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check("t6_rx0", rx_q[0], 8'h55);
         check("t6_rx1", rx_q[1], 8'hAA);
      end
      if (start_q.size() >= 2) begin
`ifdef UART_TX_PARITY_EN
         check("t6_spacing", start_q[1] - start_q[0], 958);
`else
         check("t6_spacing", start_q[1] - start_q[0], 871);
`endif
      end else begin
         check("t6_starts", start_q.size(), 2);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 SHALL have parameter BIT_CLK, default 87: clock cycles per serial bit; legal range 2..256.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-004 SHALL have port txdata, input, 8: byte to send; sampled only on handshake.
- REQ-005 SHALL have port tx_valid, input, 1: txdata is valid.
- REQ-006 SHALL have port tx_ready, output, 1: block accepts a byte this cycle.
- REQ-007 SHALL have port cts, input, 1: clear-to-send from the far-end receiver; 1 permits a new frame.
- REQ-008 SHALL have port txd, output, 1: serial line, idle high.
- REQ-009 SHALL have port busy, output, 1: high while a frame is in flight (any state other than IDLE).

Function
- REQ-010 SHALL implement states IDLE, START, DATA, PARITY (macro only), and STOP.
- REQ-011 SHALL drive tx_ready = (state==IDLE) && cts; it is combinational from registered state and cts.
- REQ-012 SHALL latch txdata on the handshake (tx_valid && tx_ready) at edge N; state becomes START at edge N+1.
- REQ-013 SHALL hold txd registered: 1 in IDLE and STOP, 0 in START, and data[index] in DATA.
- REQ-014 SHALL send data bits LSB first with a 3-bit index of 0..7.
- REQ-015 SHALL hold every state except IDLE for exactly BIT_CLK cycles, timed by an 8-bit counter 0..BIT_CLK-1 that clears on each state change.
- REQ-016 SHALL keep DATA for 8*BIT_CLK cycles and SHALL increment index when count==BIT_CLK-1.
- REQ-017 SHALL move STOP->IDLE at count==BIT_CLK-1; minimum line time between start bits = frame bits*BIT_CLK + 1 cycle.
- REQ-018 SHALL sample cts only in IDLE; cts falling mid-frame SHALL NOT abort or stretch the frame.
- REQ-019 SHALL NOT register a handshake while tx_valid is high and cts low; tx_ready stays 0, no frame starts, and txdata is not captured.
- REQ-020 SHALL ignore changes on txdata and tx_valid outside the handshake cycle.

Reset
- REQ-021 SHALL, on reset assertion, immediately (asynchronously) force state=IDLE, txd=1, busy=0, count=0, index=0, and shift data=0.
- REQ-022 SHALL drive tx_ready = cts during reset only after reset deasserts; during reset tx_ready=0.
- REQ-023 SHALL abandon a frame interrupted by reset without resuming; the line returns high at once.

Configuration
- REQ-024 SHALL recognise macro UART_TX_PARITY_EN.
- REQ-025 SHALL, with UART_TX_PARITY_EN defined, insert PARITY between DATA and STOP for BIT_CLK cycles, with txd = even parity (XOR of the 8 data bits); a frame is then 11 bits.
- REQ-026 SHALL, without UART_TX_PARITY_EN, send a 10-bit frame with no PARITY state, and no parity logic SHALL be synthesised.

Structure
- REQ-027 SHALL take its state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and default BIT_CLK from shared package uart_pkg, which the receiver also uses.
- REQ-028 SHALL factor the bit-period counter into one sub-module, uart_bit_timer (inputs: clk, reset, clear, enable; output: bit_done at count==BIT_CLK-1).

Verification (BIT_CLK=4 unless stated)
- REQ-029 Test 1: reset released, cts=1, send 0xA5 -> txd is 0,1,0,1,0,0,1,0,1,1, each level exactly 4 cycles; busy high for 40 cycles; tx_ready low in that window.
- REQ-030 Test 2: tx_valid held high, cts=0 for 20 cycles, then cts=1 -> no txd activity before cts rises; start bit begins the cycle after the first cycle with cts=1.
- REQ-031 Test 3: cts dropped at bit 3 of 0x3C -> full frame still sent; the next byte waits until cts=1.
- REQ-032 Test 4: reset pulse mid-DATA of 0xFF -> txd=1 and busy=0 within the same cycle; after release, 0x00 is sent correctly.
- REQ-033 Test 5: with UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame is 44 cycles.
- REQ-034 Test 6: BIT_CLK=87, back-to-back bytes 0x55 then 0xAA -> start-to-start spacing is 871 cycles; a loopback receiver instance recovers both bytes.
